// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: FSM states, line levels and parity.
// The transmit and receive ends both import this package.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

    // Widest payload the parity helper accepts; narrower words are zero-extended.
    localparam int unsigned PARITY_MAX_W = 64;

    function automatic logic parity_bit(input logic [PARITY_MAX_W-1:0] data,
                                        input logic                    odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/serial_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick at the terminal count.
// clear holds the count at zero so every bit period starts aligned to a state change.
module serial_baud_counter #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // tick is not gated by clear: the FSM derives clear from the transition tick causes.
    assign tick = (cnt_q == TERMINAL);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, DATA_W bits LSB first,
// optional parity bit, stop bit; each bit held for CLKS_PER_BIT clocks.
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter bit          PARITY_EN    = 1'b1,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_serial,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  idx_next;
    logic              serial_q, serial_d;
    logic              done_q, done_d;
    logic              baud_clear;
    logic              baud_tick;
    logic              parity_val;

    serial_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clock (clock),
        .reset (reset),
        .clear (baud_clear),
        .tick  (baud_tick)
    );

    assign idx_next   = idx_q + 1'b1;
    // Parity is taken from the word latched at the handshake, not the live input.
    assign parity_val = parity_bit(PARITY_MAX_W'(shift_q), PARITY_ODD);

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        serial_d = serial_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                serial_d = LINE_IDLE;
                if (tx_valid) begin
                    shift_d  = tx_data;
                    idx_d    = '0;
                    serial_d = START_BIT;
                    state_d  = START;
                end
            end

            START: begin
                if (baud_tick) begin
                    idx_d    = '0;
                    serial_d = shift_q[0];
                    state_d  = DATA;
                end
            end

            DATA: begin
                if (baud_tick) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (PARITY_EN) begin
                            serial_d = parity_val;
                            state_d  = PARITY;
                        end else begin
                            serial_d = LINE_IDLE;
                            state_d  = STOP;
                        end
                    end else begin
                        idx_d    = idx_next;
                        serial_d = shift_q[idx_next];
                    end
                end
            end

            PARITY: begin
                if (baud_tick) begin
                    idx_d    = '0;
                    serial_d = LINE_IDLE;
                    state_d  = STOP;
                end
            end

            STOP: begin
                if (baud_tick) begin
                    idx_d    = '0;
                    serial_d = LINE_IDLE;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end

            default: begin
                idx_d    = '0;
                serial_d = LINE_IDLE;
                state_d  = IDLE;
            end
        endcase
    end

    // The baud count restarts on every state change and is held at zero while idle.
    assign baud_clear = (state_q == IDLE) || (state_d != state_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            serial_q <= LINE_IDLE;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            serial_q <= serial_d;
            done_q   <= done_d;
        end
    end

    assign tx_ready  = (state_q == IDLE);
    assign tx_busy   = (state_q != IDLE);
    assign tx_serial = serial_q;
    assign tx_done   = done_q;

endmodule
